deser400_merge: RTL and testbench

- Downstream consumer of the deser400 dual-channel deserializer.
- Buffers the parallel 16-bit words written on channel A (write_a/data_a) and channel B (write_b/data_b) in two small FIFOs.
- Merges both channels into one tagged 18-bit stream using round-robin arbitration and a valid/ready handshake toward the DAQ readout.
- Counts dropped words per channel and flags each data gap in the stream.

---
 rtl/deser400_pkg.sv | 21 ++
 rtl/deser400_fifo.sv | 45 ++++
 rtl/deser400_merge.sv | 123 ++++++++++++
 tb/tb_deser400_merge.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/deser400_pkg.sv
// rtl/deser400_pkg.sv - shared constants for the deser400 merge stage
package deser400_pkg;
  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  localparam int DATA_W      = 16;
  localparam int ENTRY_W     = 17;
  localparam int OUT_W       = 18;
  localparam int OUT_CH_BIT  = 17;
  localparam int OUT_GAP_BIT = 16;

  localparam logic [7:0] DROP_MAX = 8'd255;

  function automatic logic [OUT_W-1:0] pack_word(input logic ch, input logic [ENTRY_W-1:0] entry);
    logic [OUT_W-1:0] w;
    w = '0;
    w[OUT_CH_BIT] = ch;
    w[OUT_GAP_BIT:0] = entry;
    return w;
  endfunction
endpackage

// File: rtl/deser400_fifo.sv
// rtl/deser400_fifo.sv - per-channel FIFO of {gap, data} entries, first word visible combinationally
module deser400_fifo
  import deser400_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic               clock,
  input  logic               res_n,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout,
  output logic               empty,
  output logic               full,
  output logic [AW:0]        count
);
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW:0]        wr_q;
  logic [AW:0]        rd_q;

  // Extra wrap bit on both pointers lets count reach DEPTH.
  assign count = wr_q - rd_q;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign dout  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clock or negedge res_n) begin
    if (!res_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop && !empty) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/deser400_merge.sv
// rtl/deser400_merge.sv - two-channel FIFO merge with round-robin arbitration and drop counting
module deser400_merge
  import deser400_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic              clock,
  input  logic              res_n,
  input  logic              run,
  input  logic              flush,
  input  logic              write_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              write_b,
  input  logic [DATA_W-1:0] data_b,
  output logic [OUT_W-1:0]  dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [7:0]        drop_a,
  output logic [7:0]        drop_b
);
  logic [ENTRY_W-1:0] head_a, head_b;
  logic               empty_a, empty_b, full_a, full_b;
  logic [AW:0]        count_a, count_b;
  logic               unused_counts;

  logic [OUT_W-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             rr_last_q, rr_last_d;
  logic             gap_a_q, gap_a_d, gap_b_q, gap_b_d;
  logic [7:0]       drop_a_q, drop_a_d, drop_b_q, drop_b_d;

  logic free, pop_a, pop_b, want_a, want_b, push_a, push_b, lost_a, lost_b;

  assign unused_counts = ^{count_a, count_b};

  assign free  = !valid_q || dout_ready;
  assign pop_a = free && !empty_a && (empty_b || rr_last_q == CH_B);
  assign pop_b = free && !empty_b && (empty_a || rr_last_q == CH_A);

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign want_a = write_a && run;
  assign want_b = write_b && run;
  assign push_a = want_a && (!full_a || pop_a);
  assign push_b = want_b && (!full_b || pop_b);
  assign lost_a = want_a && full_a && !pop_a;
  assign lost_b = want_b && full_b && !pop_b;

  deser400_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo_a (
    .clock(clock), .res_n(res_n), .flush(flush), .push(push_a), .pop(pop_a),
    .din({gap_a_q, data_a}), .dout(head_a), .empty(empty_a), .full(full_a), .count(count_a)
  );

  deser400_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo_b (
    .clock(clock), .res_n(res_n), .flush(flush), .push(push_b), .pop(pop_b),
    .din({gap_b_q, data_b}), .dout(head_b), .empty(empty_b), .full(full_b), .count(count_b)
  );

  always_comb begin
    dout_d    = dout_q;
    valid_d   = valid_q;
    rr_last_d = rr_last_q;
    gap_a_d   = gap_a_q;
    gap_b_d   = gap_b_q;
    drop_a_d  = drop_a_q;
    drop_b_d  = drop_b_q;

    if (pop_a) begin
      dout_d    = pack_word(CH_A, head_a);
      valid_d   = 1'b1;
      rr_last_d = CH_A;
    end else if (pop_b) begin
      dout_d    = pack_word(CH_B, head_b);
      valid_d   = 1'b1;
      rr_last_d = CH_B;
    end else if (free) begin
      valid_d = 1'b0;
    end

    if (push_a)      gap_a_d = 1'b0;
    else if (lost_a) gap_a_d = 1'b1;
    if (push_b)      gap_b_d = 1'b0;
    else if (lost_b) gap_b_d = 1'b1;

    if (lost_a && drop_a_q != DROP_MAX) drop_a_d = drop_a_q + 8'd1;
    if (lost_b && drop_b_q != DROP_MAX) drop_b_d = drop_b_q + 8'd1;

    if (flush) begin
      dout_d    = '0;
      valid_d   = 1'b0;
      rr_last_d = CH_B;
      gap_a_d   = 1'b0;
      gap_b_d   = 1'b0;
      drop_a_d  = '0;
      drop_b_d  = '0;
    end
  end

  always_ff @(posedge clock or negedge res_n) begin
    if (!res_n) begin
      dout_q    <= '0;
      valid_q   <= 1'b0;
      rr_last_q <= CH_B;
      gap_a_q   <= 1'b0;
      gap_b_q   <= 1'b0;
      drop_a_q  <= '0;
      drop_b_q  <= '0;
    end else begin
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      rr_last_q <= rr_last_d;
      gap_a_q   <= gap_a_d;
      gap_b_q   <= gap_b_d;
      drop_a_q  <= drop_a_d;
      drop_b_q  <= drop_b_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign drop_a     = drop_a_q;
  assign drop_b     = drop_b_q;
endmodule

// File: tb/tb_deser400_merge.sv
// tb/tb_deser400_merge.sv - self-checking bench for deser400_merge
module tb_deser400_merge;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clock = 1'b0;
  logic        res_n, run, flush, write_a, write_b, dout_ready;
  logic [15:0] data_a, data_b;
  logic [17:0] dout;
  logic        dout_valid;
  logic [7:0]  drop_a, drop_b;

  int checks = 0;
  int errors = 0;

  deser400_merge #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .res_n(res_n), .run(run), .flush(flush),
    .write_a(write_a), .data_a(data_a), .write_b(write_b), .data_b(data_b),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .drop_a(drop_a), .drop_b(drop_b)
  );

  always #5 clock = ~clock;

  // Reference model: per-channel queues of {gap,data}, plus the output slot.
  logic [16:0] qa[$];
  logic [16:0] qb[$];
  logic        m_gap_a, m_gap_b, m_rr, m_valid;
  logic [7:0]  m_da, m_db;
  logic [17:0] m_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete(); qb.delete();
    m_gap_a = 0; m_gap_b = 0; m_rr = 1; m_valid = 0; m_da = 0; m_db = 0; m_dout = '0;
  endtask

  task automatic model_step();
    logic [16:0] e;
    logic        ch, got, fr;
    e = '0; ch = 0; got = 0;
    if (flush) begin
      model_reset();
      return;
    end
    fr = !m_valid || dout_ready;
    if (fr) begin
      if (qa.size() > 0 && (qb.size() == 0 || m_rr)) begin
        e = qa.pop_front(); ch = 0; got = 1;
      end else if (qb.size() > 0) begin
        e = qb.pop_front(); ch = 1; got = 1;
      end
    end
    if (write_a && run) begin
      if (qa.size() < DEPTH) begin qa.push_back({m_gap_a, data_a}); m_gap_a = 0; end
      else begin m_gap_a = 1; if (m_da != 8'd255) m_da++; end
    end
    if (write_b && run) begin
      if (qb.size() < DEPTH) begin qb.push_back({m_gap_b, data_b}); m_gap_b = 0; end
      else begin m_gap_b = 1; if (m_db != 8'd255) m_db++; end
    end
    if (got) begin m_dout = {ch, e}; m_valid = 1; m_rr = ch; end
    else if (fr) m_valid = 0;
  endtask

  task automatic cycle();
    logic        pv, pr, pf;
    logic [17:0] pd;
    pv = dout_valid; pr = dout_ready; pf = flush; pd = dout;
    @(posedge clock);
    model_step();
    @(negedge clock);
    chk("valid", 32'(dout_valid), 32'(m_valid));
    chk("dout", 32'(dout), 32'(m_dout));
    chk("drop_a", 32'(drop_a), 32'(m_da));
    chk("drop_b", 32'(drop_b), 32'(m_db));
    if (pv && !pr && !pf) chk("stable", 32'(dout), 32'(pd));
  endtask

  task automatic set_in(input logic wa, input logic [15:0] da, input logic wb,
                        input logic [15:0] db, input logic rdy);
    write_a = wa; data_a = da; write_b = wb; data_b = db; dout_ready = rdy;
  endtask

  task automatic do_flush();
    flush = 1; cycle(); flush = 0;
  endtask

  typedef struct {
    logic        wa;
    logic [15:0] da;
    logic        wb;
    logic [15:0] db;
    logic        rdy;
    logic        ev;
    logic [17:0] edout;
  } vec_t;

  vec_t tbl[12];
  logic [17:0] seen[$];
  int ngap;

  initial begin
    tbl[0]  = '{1'b1, 16'd1, 1'b1, 16'd10, 1'b0, 1'b0, 18'h00000};
    tbl[1]  = '{1'b1, 16'd2, 1'b1, 16'd20, 1'b0, 1'b1, 18'h00001};
    tbl[2]  = '{1'b1, 16'd3, 1'b1, 16'd30, 1'b0, 1'b1, 18'h00001};
    tbl[3]  = '{1'b0, 16'd0, 1'b0, 16'd0,  1'b1, 1'b1, 18'h2000A};
    tbl[4]  = '{1'b0, 16'd0, 1'b0, 16'd0,  1'b1, 1'b1, 18'h00002};
    tbl[5]  = '{1'b0, 16'd0, 1'b0, 16'd0,  1'b1, 1'b1, 18'h20014};
    tbl[6]  = '{1'b0, 16'd0, 1'b0, 16'd0,  1'b1, 1'b1, 18'h00003};
    tbl[7]  = '{1'b0, 16'd0, 1'b0, 16'd0,  1'b1, 1'b1, 18'h2001E};
    tbl[8]  = '{1'b0, 16'd0, 1'b0, 16'd0,  1'b1, 1'b0, 18'h2001E};
    tbl[9]  = '{1'b1, 16'hA5A5, 1'b0, 16'd0, 1'b1, 1'b0, 18'h2001E};
    tbl[10] = '{1'b0, 16'd0, 1'b0, 16'd0,  1'b1, 1'b1, 18'h0A5A5};
    tbl[11] = '{1'b0, 16'd0, 1'b0, 16'd0,  1'b1, 1'b0, 18'h0A5A5};

    res_n = 0; run = 1; flush = 0;
    set_in(0, 0, 0, 0, 0);
    model_reset();
    #1;
    chk("rst_dout", 32'(dout), 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_drop_a", 32'(drop_a), 0);
    chk("rst_drop_b", 32'(drop_b), 0);
    @(negedge clock);
    res_n = 1;

    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].wa, tbl[i].da, tbl[i].wb, tbl[i].db, tbl[i].rdy);
      cycle();
      chk($sformatf("tbl%0d_valid", i), 32'(dout_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].edout));
    end

    // Async reset while holding a word and 5 drops.
    for (int i = 0; i < 14; i++) begin set_in(1, 16'(i), 0, 0, 0); cycle(); end
    set_in(0, 0, 0, 0, 0);
    chk("pre_rst_drop_a", 32'(drop_a), 5);
    chk("pre_rst_valid", 32'(dout_valid), 1);
    #2 res_n = 0;
    #1;
    chk("arst_dout", 32'(dout), 0);
    chk("arst_valid", 32'(dout_valid), 0);
    chk("arst_drop_a", 32'(drop_a), 0);
    model_reset();
    @(negedge clock);
    res_n = 1;

    // Same via flush.
    for (int i = 0; i < 14; i++) begin set_in(1, 16'(i + 50), 0, 0, 0); cycle(); end
    set_in(0, 0, 0, 0, 0);
    chk("pre_fl_drop_a", 32'(drop_a), 5);
    do_flush();
    chk("fl_dout", 32'(dout), 0);
    chk("fl_valid", 32'(dout_valid), 0);
    chk("fl_drop_a", 32'(drop_a), 0);

    // Overflow on B with the output slot held.
    for (int i = 0; i < 11; i++) begin set_in(0, 0, 1, 16'h100 + 16'(i), 0); cycle(); end
    chk("ovf_drop_b", 32'(drop_b), 2);
    seen.delete();
    if (dout_valid) seen.push_back(dout);
    set_in(0, 0, 1, 16'h1FF, 1);
    cycle();
    set_in(0, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) begin
      if (dout_valid) seen.push_back(dout);
      cycle();
    end
    ngap = 0;
    foreach (seen[j]) if (seen[j][16]) ngap++;
    chk("ovf_words", 32'(seen.size()), 10);
    chk("ovf_gap_count", 32'(ngap), 1);
    if (seen.size() == 10) chk("ovf_gap_last", 32'(seen[9]), 32'(18'h301FF));
    chk("ovf_drop_b_hold", 32'(drop_b), 2);

    // Saturation on A.
    do_flush();
    for (int i = 0; i < 309; i++) begin set_in(1, 16'(i), 0, 0, 0); cycle(); end
    chk("sat_drop_a", 32'(drop_a), 255);
    cycle();
    chk("sat_drop_a_hold", 32'(drop_a), 255);
    ngap = 0;
    set_in(1, 16'hBEEF, 0, 0, 1); cycle();
    set_in(1, 16'hCAFE, 0, 0, 1); cycle();
    set_in(0, 0, 0, 0, 1);
    for (int k = 0; k < 15; k++) begin
      if (dout_valid && dout[16]) ngap++;
      cycle();
    end
    chk("sat_gap_words", 32'(ngap), 1);
    chk("sat_drop_a_end", 32'(drop_a), 255);

    // Randomized streaming with backpressure.
    do_flush();
    for (int i = 0; i < 3000; i++) begin
      run = ($urandom_range(0, 15) != 0);
      flush = ($urandom_range(0, 499) == 0);
      set_in(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
             16'($urandom), 1'($urandom_range(0, 1)));
      cycle();
    end
    flush = 0; run = 1;

    // run=0 ignores writes even when they would overflow.
    do_flush();
    for (int i = 0; i < 9; i++) begin set_in(1, 16'(i), 0, 0, 0); cycle(); end
    run = 0;
    for (int i = 0; i < 3; i++) begin set_in(1, 16'h7777, 0, 0, 0); cycle(); end
    chk("run0_drop_a", 32'(drop_a), 0);
    set_in(0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) cycle();
    chk("run0_drained", 32'(dout_valid), 0);
    run = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
